// File: rtl/ecpri_axil_regs.sv
// ---------------------------------------------------------------------------
// ecpri_axil_regs
// AXI4-Lite slave register bank for the eCPRI IP. Exposes four read/write
// configuration words to the eCPRI core, a read-only status word, a
// write-one-to-clear interrupt status word, an interrupt enable word and a
// constant version word. Single clock domain (ACLK).
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   S_AXI_AW*            write address channel (PROT ignored)
//   S_AXI_W*             write data channel with byte strobes
//   S_AXI_B*             write response channel
//   S_AXI_AR*            read address channel (PROT ignored)
//   S_AXI_R*             read data channel
//   ctrl_o, cfg0_o..2_o  register contents driven to the core
//   status_i             core status, sampled when STATUS is read
//   irq_event_i          per-bit single-cycle interrupt event pulses
//   irq_o                registered OR of (IRQ_STAT & IRQ_EN)
//
// Map (word slot = ADDR[5:2]):
//   0 CTRL RW, 1 CFG0 RW, 2 CFG1 RW, 3 CFG2 RW, 4 STATUS RO,
//   5 IRQ_STAT W1C, 6 IRQ_EN RW, 7 VERSION RO, 8..15 unmapped (SLVERR)
// ---------------------------------------------------------------------------
module ecpri_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] C_VERSION          = 32'h0001_0000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cfg2_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     irq_event_i,
    output logic                              irq_o
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int SLOT_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [SLOT_W-1:0] SLOT_CTRL     = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_CFG0     = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_CFG1     = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] SLOT_CFG2     = SLOT_W'(3);
    localparam logic [SLOT_W-1:0] SLOT_IRQ_STAT = SLOT_W'(5);
    localparam logic [SLOT_W-1:0] SLOT_IRQ_EN   = SLOT_W'(6);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(7);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

    // Expand byte strobes into a bit mask over the data word.
    function automatic word_t strb_mask(input logic [STRB_W-1:0] strb);
        word_t m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Held write address / data
    logic              aw_held;
    logic              w_held;
    logic [SLOT_W-1:0] aw_slot;
    word_t             w_data;
    logic [STRB_W-1:0] w_strb;

    // Response channels
    logic              bvalid;
    logic [1:0]        bresp;
    logic              rvalid;
    logic [1:0]        rresp;
    word_t             rdata;

    // Register file
    word_t             ctrl;
    word_t             cfg0;
    word_t             cfg1;
    word_t             cfg2;
    word_t             irq_stat;
    word_t             irq_en;
    logic              irq;

    logic              aw_fire;
    logic              w_fire;
    logic              commit;
    logic              ar_fire;
    logic              wr_err;
    logic [SLOT_W-1:0] ar_slot;
    word_t             wmask;
    word_t             irq_clr;
    word_t             rd_word;
    logic              rd_err;

    // PROT and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_fire = S_AXI_AWVALID && !aw_held;
    assign w_fire  = S_AXI_WVALID && !w_held;
    // A new response can only be issued once the previous one is taken
    // (or is being taken this very cycle).
    assign commit  = aw_held && w_held && (!bvalid || S_AXI_BREADY);
    assign ar_fire = S_AXI_ARVALID && !rvalid;
    assign ar_slot = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wmask   = strb_mask(w_strb);
    assign wr_err  = (aw_slot > SLOT_LAST);

    // W1C clear mask; applied before event set so a coincident event wins.
    assign irq_clr = (commit && (aw_slot == SLOT_IRQ_STAT)) ? (w_data & wmask) : '0;

    // Read decode; registers are read as they stand before any same-cycle commit.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (ar_slot > SLOT_LAST) begin
            rd_err = 1'b1;
        end else begin
            case (ar_slot[2:0])
                3'd0:    rd_word = ctrl;
                3'd1:    rd_word = cfg0;
                3'd2:    rd_word = cfg1;
                3'd3:    rd_word = cfg2;
                3'd4:    rd_word = status_i;
                3'd5:    rd_word = irq_stat;
                3'd6:    rd_word = irq_en;
                default: rd_word = word_t'(C_VERSION);
            endcase
        end
    end

    // Write channel: capture AW and W independently, commit when both held.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_slot <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_slot <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                bvalid  <= 1'b0;
            end
        end
    end

    // Register file and interrupt logic
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl     <= '0;
            cfg0     <= '0;
            cfg1     <= '0;
            cfg2     <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            if (commit) begin
                case (aw_slot)
                    SLOT_CTRL:   ctrl   <= (ctrl   & ~wmask) | (w_data & wmask);
                    SLOT_CFG0:   cfg0   <= (cfg0   & ~wmask) | (w_data & wmask);
                    SLOT_CFG1:   cfg1   <= (cfg1   & ~wmask) | (w_data & wmask);
                    SLOT_CFG2:   cfg2   <= (cfg2   & ~wmask) | (w_data & wmask);
                    SLOT_IRQ_EN: irq_en <= (irq_en & ~wmask) | (w_data & wmask);
                    default:     ;
                endcase
            end
            irq_stat <= (irq_stat & ~irq_clr) | irq_event_i;
            irq      <= |(irq_stat & irq_en);
        end
    end

    // Read channel: one outstanding read, response held until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else begin
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = !aw_held;
    assign S_AXI_WREADY  = !w_held;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = !rvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign ctrl_o        = ctrl;
    assign cfg0_o        = cfg0;
    assign cfg1_o        = cfg1;
    assign cfg2_o        = cfg2;
    assign irq_o         = irq;

endmodule

// File: tb/tb_ecpri_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_ecpri_axil_regs
// Self-checking bench for ecpri_axil_regs: directed scenarios plus a
// randomized write/read mix, compared against a transaction-level register
// model kept in the bench.
// ---------------------------------------------------------------------------
module tb_ecpri_axil_regs;

    logic        ACLK;
    logic        ARESETN;
    logic [5:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [5:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] ctrl_o, cfg0_o, cfg1_o, cfg2_o;
    logic [31:0] status_i;
    logic [31:0] irq_event_i;
    logic        irq_o;

    ecpri_axil_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_o(ctrl_o), .cfg0_o(cfg0_o), .cfg1_o(cfg1_o), .cfg2_o(cfg2_o),
        .status_i(status_i), .irq_event_i(irq_event_i), .irq_o(irq_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_reg [0:3] = '{default: 32'h0};
    logic [31:0] m_stat = 32'h0;
    logic [31:0] m_en   = 32'h0;
    logic        m_irq  = 1'b0;
    int          cyc    = 0;

    // Write scheduled to land on edge number sched_edge
    int          sched_edge = -1;
    logic [5:0]  sched_addr = 6'h0;
    logic [31:0] sched_data = 32'h0;
    logic [3:0]  sched_strb = 4'h0;

    logic        cmp_on   = 1'b0;
    logic        ev_rand  = 1'b0;
    logic [31:0] ev_force = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // {resp, data} a read of address a returns given the current model
    function automatic logic [33:0] model_rd(input logic [5:0] a, input logic [31:0] st);
        case (a[5:2])
            4'd0, 4'd1, 4'd2, 4'd3: return {2'b00, m_reg[a[3:2]]};
            4'd4:    return {2'b00, st};
            4'd5:    return {2'b00, m_stat};
            4'd6:    return {2'b00, m_en};
            4'd7:    return {2'b00, 32'h0001_0000};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Reference model: register file updated per edge
    initial begin
        logic [31:0] clr, mk;
        forever begin
            @(posedge ACLK or negedge ARESETN);
            if (!ARESETN) begin
                for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
                m_stat = 32'h0;
                m_en   = 32'h0;
                m_irq  = 1'b0;
            end else begin
                cyc++;
                m_irq = |(m_stat & m_en);
                clr   = 32'h0;
                if (cyc == sched_edge) begin
                    mk = byte_mask(sched_strb);
                    case (sched_addr[5:2])
                        4'd0, 4'd1, 4'd2, 4'd3:
                            m_reg[sched_addr[3:2]] = (m_reg[sched_addr[3:2]] & ~mk) | (sched_data & mk);
                        4'd5: clr = sched_data & mk;
                        4'd6: m_en = (m_en & ~mk) | (sched_data & mk);
                        default: ;
                    endcase
                end
                m_stat = (m_stat & ~clr) | irq_event_i;
            end
        end
    end

    // Interrupt event driver
    initial begin
        irq_event_i = 32'h0;
        forever begin
            @(posedge ACLK);
            #2;
            irq_event_i = ev_rand ? ($urandom & $urandom & $urandom) : ev_force;
        end
    end

    // Per-cycle output compare
    initial begin
        forever begin
            @(negedge ACLK);
            if (cmp_on) begin
                chk("ctrl_o", ctrl_o, m_reg[0]);
                chk("cfg0_o", cfg0_o, m_reg[1]);
                chk("cfg1_o", cfg1_o, m_reg[2]);
                chk("cfg2_o", cfg2_o, m_reg[3]);
                chk("irq_o", 32'(irq_o), 32'(m_irq));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Full write with skew (>0: W leads, <0: AW leads) and B backpressure.
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew, input int bhold);
        int t_aw, t_w, t_last;
        logic [1:0] exp_resp;
        t_aw     = (skew > 0) ? skew : 0;
        t_w      = (skew < 0) ? -skew : 0;
        t_last   = (t_aw > t_w) ? t_aw : t_w;
        exp_resp = a[5] ? 2'b10 : 2'b00;
        for (int c = 0; c <= t_last; c++) begin
            if (c == t_aw) begin
                S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
                chk("wr_awready", 32'(S_AXI_AWREADY), 32'd1);
            end
            if (c == t_w) begin
                S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
                chk("wr_wready", 32'(S_AXI_WREADY), 32'd1);
            end
            @(posedge ACLK); #1;
            if (c == t_aw) S_AXI_AWVALID = 1'b0;
            if (c == t_w)  S_AXI_WVALID  = 1'b0;
            if (c < t_last) begin
                if (c >= t_w)  chk("wr_wready_held", 32'(S_AXI_WREADY), 32'd0);
                if (c >= t_aw) chk("wr_awready_held", 32'(S_AXI_AWREADY), 32'd0);
                chk("wr_bvalid_early", 32'(S_AXI_BVALID), 32'd0);
            end
        end
        chk("wr_bvalid_early", 32'(S_AXI_BVALID), 32'd0);
        sched_addr = a; sched_data = d; sched_strb = s; sched_edge = cyc + 1;
        @(posedge ACLK); #1;
        chk("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("wr_bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        for (int i = 0; i < bhold; i++) begin
            @(posedge ACLK); #1;
            chk("wr_bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            chk("wr_bresp_hold", 32'(S_AXI_BRESP), 32'(exp_resp));
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("wr_bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    endtask

    // Full read with R backpressure of rhold cycles.
    task automatic do_read(input logic [5:0] a, input int rhold,
                           output logic [31:0] got_d, output logic [1:0] got_r);
        logic [33:0] e;
        logic [31:0] st;
        st = $urandom;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; status_i = st;
        chk("rd_arready", 32'(S_AXI_ARREADY), 32'd1);
        e = model_rd(a, st);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        chk("rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
        chk("rd_data", S_AXI_RDATA, e[31:0]);
        chk("rd_resp", 32'(S_AXI_RRESP), 32'(e[33:32]));
        got_d = S_AXI_RDATA;
        got_r = S_AXI_RRESP;
        for (int i = 0; i < rhold; i++) begin
            @(posedge ACLK); #1;
            chk("rd_rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            chk("rd_data_hold", S_AXI_RDATA, e[31:0]);
            chk("rd_arready_busy", 32'(S_AXI_ARREADY), 32'd0);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        chk("rd_rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd1);
        chk({tag, "_wready"},  32'(S_AXI_WREADY),  32'd1);
        chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd1);
        chk({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'd0);
        chk({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'd0);
        chk({tag, "_bresp"},   32'(S_AXI_BRESP),   32'd0);
        chk({tag, "_rresp"},   32'(S_AXI_RRESP),   32'd0);
        chk({tag, "_rdata"},   S_AXI_RDATA,        32'd0);
        chk({tag, "_ctrl"},    ctrl_o,             32'd0);
        chk({tag, "_cfg0"},    cfg0_o,             32'd0);
        chk({tag, "_cfg1"},    cfg1_o,             32'd0);
        chk({tag, "_cfg2"},    cfg2_o,             32'd0);
        chk({tag, "_irq"},     32'(irq_o),         32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [5:0]  wa, ra;
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        status_i = '0;

        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs("rst");
        cmp_on  = 1'b1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Basic write/readback
        for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(6'(i * 4), 0, rd, rr);
            chk("basic_rd", rd, 32'(i + 1));
            chk("basic_resp", 32'(rr), 32'd0);
        end
        chk("basic_cfg0", cfg0_o, 32'd2);
        chk("basic_cfg2", cfg2_o, 32'd4);

        // Byte strobe merge
        do_write(6'h04, 32'hAABBCCDD, 4'b0010, 0, 0);
        do_read(6'h04, 0, rd, rr);
        chk("strb_cfg0", rd, 32'h0000CC02);

        // W leads AW by 3 cycles
        do_write(6'h00, 32'h5A5A0001, 4'hF, 3, 0);
        chk("skew_ctrl", ctrl_o, 32'h5A5A0001);
        do_write(6'h08, 32'h0000_0003, 4'hF, -2, 2);

        // Unmapped and version
        do_read(6'h24, 0, rd, rr);
        chk("unmap_rd_data", rd, 32'd0);
        chk("unmap_rd_resp", 32'(rr), 32'd2);
        do_write(6'h30, 32'hFFFFFFFF, 4'hF, 0, 1);
        chk("unmap_wr_ctrl", ctrl_o, 32'h5A5A0001);
        chk("unmap_wr_cfg1", cfg1_o, 32'd3);
        do_read(6'h1C, 0, rd, rr);
        chk("version", rd, 32'h0001_0000);
        do_write(6'h1C, 32'h1234_5678, 4'hF, 0, 0);
        do_read(6'h1F, 0, rd, rr);
        chk("version_ro", rd, 32'h0001_0000);

        // Interrupts
        do_write(6'h18, 32'h8, 4'hF, 0, 0);
        ev_force = 32'h8;
        @(posedge ACLK); #1;
        ev_force = 32'h0;
        @(posedge ACLK); #1;
        chk("irq_set", 32'(irq_o), 32'd1);
        fork
            do_write(6'h14, 32'h8, 4'hF, 0, 0);
            begin
                @(posedge ACLK); #1;
                ev_force = 32'h8;
                @(posedge ACLK); #1;
                ev_force = 32'h0;
            end
        join
        do_read(6'h14, 0, rd, rr);
        chk("irq_set_wins", rd, 32'h8);
        chk("irq_still", 32'(irq_o), 32'd1);
        do_write(6'h14, 32'h8, 4'hF, 0, 0);
        chk("irq_cleared", 32'(irq_o), 32'd0);
        do_read(6'h14, 0, rd, rr);
        chk("irq_stat_clr", rd, 32'd0);

        // Read backpressure
        do_read(6'h08, 5, rd, rr);
        chk("rhold_data", rd, 32'd3);

        // Commit stalls behind an unaccepted response
        S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h1111_2222; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        sched_addr = 6'h08; sched_data = 32'h1111_2222; sched_strb = 4'hF; sched_edge = cyc + 1;
        @(posedge ACLK); #1;
        chk("stall_b1", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h3333_4444;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge ACLK); #1;
            chk("stall_awready", 32'(S_AXI_AWREADY), 32'd0);
            chk("stall_bvalid", 32'(S_AXI_BVALID), 32'd1);
            chk("stall_cfg2", cfg2_o, 32'd4);
        end
        sched_addr = 6'h0C; sched_data = 32'h3333_4444; sched_strb = 4'hF; sched_edge = cyc + 1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("stall_b2", 32'(S_AXI_BVALID), 32'd1);
        chk("stall_cfg2_new", cfg2_o, 32'h3333_4444);
        chk("stall_cfg1_new", cfg1_o, 32'h1111_2222);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("stall_bclr", 32'(S_AXI_BVALID), 32'd0);

        // Randomized mix
        ev_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : {1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : {1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                fork
                    do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 6) - 3, $urandom_range(0, 3));
                    do_read(ra, $urandom_range(0, 3), rd, rr);
                join
            end else begin
                do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 6) - 3, $urandom_range(0, 3));
            end
        end
        ev_rand = 1'b0;
        do_write(6'h00, 32'hCAFE_0001, 4'hF, 0, 0);
        do_read(6'h08, 0, rd, rr);

        // Reset in the middle of a write
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        ARESETN = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("post_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        chk("post_rst_ctrl", ctrl_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecpri_axil_regs.md
# ecpri_axil_regs

AXI4-Lite slave register bank for the eCPRI IP, answering the S00_AXI write/read traffic issued by the master VIP. It exposes four read/write configuration words to the eCPRI core, plus a read-only status word, a W1C interrupt status word, an interrupt enable word and a version word. It sits between the block-design AXI interconnect and the eCPRI datapath, all in the single ACLK domain.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 6, byte address width; 16 word slots, 8 implemented
- C_VERSION, 32'h0001_0000, constant returned at 0x1C
- ACLK  in  1  clock; all logic rising-edge
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  6/3/1/1  write address channel; PROT ignored
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  6/3/1/1  read address; PROT ignored
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data
- ctrl_o, cfg0_o, cfg1_o, cfg2_o  out  32 each  register contents to core
- status_i  in  32  core status, sampled on read
- irq_event_i  in  32  single-cycle event pulses per bit
- irq_o  out  1  registered OR of (IRQ_STAT & IRQ_EN)

## Operation
- Map (word address = ADDR[5:2]): 0x00 CTRL RW, 0x04 CFG0 RW, 0x08 CFG1 RW, 0x0C CFG2 RW, 0x10 STATUS RO, 0x14 IRQ_STAT W1C, 0x18 IRQ_EN RW, 0x1C VERSION RO. ADDR[1:0] ignored.
- 0x20–0x3C unmapped: writes ignored with BRESP=SLVERR(2'b10); reads return 0 with RRESP=SLVERR. Writes to RO slots ignored, BRESP=OKAY.
- Write path: AW and W are accepted independently. aw_held set on AW handshake (address latched), w_held set on W handshake (data+strobe latched). AWREADY = !aw_held, WREADY = !w_held.
- Commit when aw_held && w_held && (!BVALID || BREADY): update target per WSTRB byte lanes, clear both held flags, raise BVALID with the response.
- IRQ_STAT: bit sets when irq_event_i bit is 1; W1C clears bits written 1 in strobed bytes; same-cycle set and clear → set wins.
- Read path: ARREADY = !RVALID. On AR handshake, RDATA/RRESP registered from the decoded address (STATUS samples status_i that cycle), RVALID=1. Held stable until RREADY.
- Read and write channels are fully independent; a same-cycle read of a register being committed returns the pre-write value.

## Timing
- Reset (async assert, sync release): AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, all registers 0, irq_o=0, held flags 0.
- Write latency: BVALID rises on the edge after the later of the AW/W handshakes (AW+W same cycle → BVALID 1 cycle later). Register outputs update on the same edge as BVALID rises.
- Throughput: at most one write per 2 cycles (READY deasserts while held).
- Read latency: RVALID rises 1 cycle after the AR handshake; max one read per 2 cycles with RREADY held high.
- B/R backpressure: BVALID/RVALID, BRESP, RDATA stay stable until ready; a pending commit stalls while BVALID && !BREADY.
- irq_o lags an IRQ_STAT/IRQ_EN change by 1 cycle.
- Reset mid-transaction: all pending handshakes dropped, no partial register update.

## Test plan
- Write 1,2,3,4 to 0x00,0x04,0x08,0x0C (AW+W together) → BRESP=OKAY each; read back → 1,2,3,4, RRESP=OKAY; cfg*_o match.
- WSTRB=4'b0010, WDATA=32'hAABBCCDD to 0x04 holding 0x00000002 → CFG0=0x0000CC02.
- W presented 3 cycles before AW to 0x00 → WREADY low after the W handshake, BVALID 1 cycle after AW handshake, CTRL updated.
- Read 0x24 → RDATA=0, RRESP=SLVERR; write 0x30 → BRESP=SLVERR, no register changed; read 0x1C → 0x00010000.
- irq_event_i[3] pulse, IRQ_EN=0x8 → irq_o=1; write 0x8 to 0x14 in the same cycle as a second bit-3 pulse → bit stays set; a later clear → IRQ_STAT=0, irq_o=0 next cycle.
- RREADY held low 5 cycles after read of 0x08 → RVALID/RDATA stable, ARREADY=0 until accepted; assert ARESETN low mid-write → all outputs at reset values.
